// File: rtl/router_input_unit_pkg.sv
// Shared router definitions: direction/field widths, info codes, input-unit
// state encoding and flit field offsets.
package router_input_unit_pkg;

    localparam int DIRECTION         = 5;
    localparam int ROUTER_INFO_WIDTH = 2;
    localparam int ROUTER_ADDR_WIDTH = 8;

    typedef enum logic [ROUTER_INFO_WIDTH-1:0] {
        ROUTER_INFO_CONFIG = 2'd0,
        ROUTER_INFO_DATA   = 2'd1,
        ROUTER_INFO_REDUCE = 2'd2,
        ROUTER_INFO_GATHER = 2'd3
    } routeInfo_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUTE  = 2'd1,
        ACTIVE = 2'd2
    } iuState_e;

    // A flit is packed {info, addr, data} with info in the MSBs.
    function automatic int flitWidth(input int dataWidth);
        return ROUTER_INFO_WIDTH + ROUTER_ADDR_WIDTH + dataWidth;
    endfunction

    function automatic int addrLsb(input int dataWidth);
        return dataWidth;
    endfunction

    function automatic int infoLsb(input int dataWidth);
        return dataWidth + ROUTER_ADDR_WIDTH;
    endfunction

endpackage

// File: rtl/router_input_unit_if.sv
// Bundle of the upstream link, routing-computer and switch-allocator signals
// seen by one router input unit.
interface router_input_unit_if #(
    parameter int DATA_WIDTH = 32
);
    import router_input_unit_pkg::*;

    localparam int FLIT_W = flitWidth(DATA_WIDTH);

    logic                         in_valid;
    logic                         in_ready;
    logic [FLIT_W-1:0]            in_flit;
    logic                         rc_en;
    logic [ROUTER_INFO_WIDTH-1:0] rc_route_info;
    logic [ROUTER_ADDR_WIDTH-1:0] rc_route_addr;
    logic [DIRECTION-1:0]         rc_route_port;
    logic [DIRECTION-1:0]         sa_req;
    logic [DIRECTION-1:0]         sa_grant;
    logic [FLIT_W-1:0]            out_flit;
    logic                         drop_pulse;

    // The environment (upstream, routing computer, allocator) drives the master side.
    modport master (
        output in_valid, in_flit, rc_route_port, sa_grant,
        input  in_ready, rc_en, rc_route_info, rc_route_addr, sa_req, out_flit, drop_pulse
    );

    modport slave (
        input  in_valid, in_flit, rc_route_port, sa_grant,
        output in_ready, rc_en, rc_route_info, rc_route_addr, sa_req, out_flit, drop_pulse
    );

endinterface

// File: rtl/router_input_unit_fifo.sv
// Circular flit buffer with registered storage, wrapping pointers and an
// occupancy count; pushes while full and pops while empty are ignored.
module router_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 42
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == FULL_COUNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rdPtr];

    // Storage carries no reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/router_input_unit.sv
// Router input port stage: buffers flits, asks the routing computer for the
// head flit's outputs, then requests the switch allocator until all are granted.
module router_input_unit #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32
) (
    input logic               clk,
    input logic               rst,
    router_input_unit_if.slave bus
);
    import router_input_unit_pkg::*;

    localparam int FLIT_W   = flitWidth(DATA_WIDTH);
    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int INFO_LSB = infoLsb(DATA_WIDTH);
    localparam int ADDR_LSB = addrLsb(DATA_WIDTH);

    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [CNT_W-1:0]     w_count;
    logic [CNT_W-1:0]     w_countNext;
    logic                 w_moreAfter;
    logic [FLIT_W-1:0]    w_head;
    logic [DIRECTION-1:0] w_remain;
    logic                 w_routeDrop;
    logic                 w_allGranted;

    iuState_e             r_state;
    logic [DIRECTION-1:0] r_pending;
    logic [DIRECTION-1:0] r_saReq;
    logic                 r_rcEn;
    logic                 r_drop;

    router_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FLIT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (bus.in_flit),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bus.in_ready      = !w_full;
    assign w_push            = bus.in_valid && !w_full;

    assign w_remain          = r_pending & ~bus.sa_grant;
    assign w_routeDrop       = (r_state == ROUTE) && (bus.rc_route_port == '0);
    assign w_allGranted      = (r_state == ACTIVE) && (w_remain == '0);
    assign w_pop             = (w_routeDrop || w_allGranted) && !w_empty;

    // Occupancy after this cycle's push and pop decides whether another flit follows.
    assign w_countNext       = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_moreAfter       = (w_countNext != '0);

    assign bus.rc_en         = r_rcEn;
    assign bus.sa_req        = r_saReq;
    assign bus.drop_pulse    = r_drop;
    assign bus.out_flit      = w_head;
    assign bus.rc_route_info = w_head[INFO_LSB +: ROUTER_INFO_WIDTH];
    assign bus.rc_route_addr = w_head[ADDR_LSB +: ROUTER_ADDR_WIDTH];

    // rc_en, sa_req and drop_pulse are registered against the next state so
    // they line up with the cycle the FSM actually spends in ROUTE/ACTIVE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_saReq   <= '0;
            r_rcEn    <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_rcEn  <= 1'b0;
            r_drop  <= 1'b0;
            r_saReq <= '0;
            case (r_state)
                IDLE: begin
                    if (w_moreAfter) begin
                        r_state <= ROUTE;
                        r_rcEn  <= 1'b1;
                    end
                end
                ROUTE: begin
                    r_pending <= bus.rc_route_port;
                    if (w_routeDrop) begin
                        r_drop <= 1'b1;
                        if (w_moreAfter) begin
                            r_state <= ROUTE;
                            r_rcEn  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_state <= ACTIVE;
                        r_saReq <= bus.rc_route_port;
                    end
                end
                ACTIVE: begin
                    r_pending <= w_remain;
                    if (w_allGranted) begin
                        if (w_moreAfter) begin
                            r_state <= ROUTE;
                            r_rcEn  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_saReq <= w_remain;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/router_input_unit.md
Name: router_input_unit

Overview:
- Per-port input stage of the quadtree router. One instance sits on each of the 5 router input ports, directly upstream of that port's routing computer.
- Buffers incoming single-flit packets in a FIFO and presents the head flit's route_info/route_addr to the routing computer with rc_en.
- Latches the returned route_port as a pending-output mask and requests the switch allocator for every set bit, including multicast/broadcast masks.
- Pops the flit once every requested output has been granted.

Parameters:
- DEPTH, 4: FIFO entries; must be a power of two, >= 2.
- DATA_WIDTH, 32: payload bits carried alongside route_info and route_addr.
- Flit width is `ROUTER_INFO_WIDTH + `ROUTER_ADDR_WIDTH + DATA_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream flit valid
- in_ready  out  1  FIFO can accept a flit
- in_flit  in  FLIT_W  packed as {info, addr, data}, info in the MSBs
- rc_en  out  1  enable to the routing computer
- rc_route_info  out  `ROUTER_INFO_WIDTH  head flit info
- rc_route_addr  out  `ROUTER_ADDR_WIDTH  head flit address
- rc_route_port  in  `DIRECTION  routing computer result (combinational)
- sa_req  out  `DIRECTION  pending output requests
- sa_grant  in  `DIRECTION  per-output grant for this input
- out_flit  out  FLIT_W  head flit, toward the crossbar
- drop_pulse  out  1  one-cycle pulse when an unroutable flit is discarded

Behaviour:
- Reset values (synchronous): FIFO empty; in_ready=1; rc_en=0; sa_req=0; drop_pulse=0; state=IDLE. A reset mid-operation discards all buffered flits and the pending mask.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready = !full. There is no same-cycle push-while-full, even if a pop also occurs that cycle.
  - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
  - A pushed flit reaches the head on the next cycle; there is no bypass.
- rc_route_info, rc_route_addr and out_flit always reflect the FIFO head. They are don't-care when the FIFO is empty.
- State IDLE:
  - FIFO empty -> stay in IDLE.
  - Non-empty -> go to ROUTE.
- State ROUTE:
  - rc_en=1 for exactly this cycle.
  - Register pending <= rc_route_port.
  - If rc_route_port==0: pop the head and assert drop_pulse on the next cycle. Then go to ROUTE if flits remain after the pop, otherwise IDLE.
  - Otherwise go to ACTIVE.
- State ACTIVE:
  - sa_req = pending.
  - Each cycle: pending <= pending & ~sa_grant.
  - Grant bits outside pending are ignored.
  - When (pending & ~sa_grant)==0: pop the head that cycle. Go to ROUTE if count after pop and push is >0, otherwise IDLE.
  - Partial grants keep the flit at the head, and out_flit stays stable.
- Minimum latency: push at cycle t -> ROUTE at t+1 -> sa_req at t+2. With grant at t+2, the next flit enters ROUTE at t+3. Throughput is at most 1 flit per 2 cycles.
- sa_req is 0 in IDLE and ROUTE. rc_en is 0 outside ROUTE.
- Simultaneous push and pop in the same cycle: count is unchanged and both pointers advance.

Decomposition:
- Shared router package/header (router.vh), which supplies:
  - `DIRECTION
  - `ROUTER_INFO_WIDTH and `ROUTER_ADDR_WIDTH
  - ROUTER_INFO_* codes
  - the state encoding (IDLE=2'd0, ROUTE=2'd1, ACTIVE=2'd2)
  - flit field offset macros
- One sub-module is natural: router_fifo (DEPTH, WIDTH). It provides push/pop/full/empty/count, synchronous reset and registered storage.

Test Plan:
- Reset, then push one CONFIG flit; RC model returns 5'b00100 -> rc_en high 1 cycle, sa_req=5'b00100 next cycle; grant 5'b00100 -> pop, return to IDLE, in_ready=1.
- Broadcast mask 5'b01111: grants 5'b00011, then 5'b01000, then 5'b00100 on successive cycles -> sa_req steps 01111 -> 01100 -> 00100 -> 0. The pop occurs on the third grant, and out_flit is unchanged throughout.
- RC model returns 5'b00000 -> no sa_req, drop_pulse exactly 1 cycle, next flit enters ROUTE immediately.
- Fill DEPTH=4 with no grants -> in_ready=0 after 4 pushes. Push attempt while full is ignored. Push offered in the same cycle as the pop is refused, and accepted on the next cycle.
- Stream 10 flits across pointer wrap, grant always 5'b11111 -> flits delivered in order, one per 2 cycles, no loss or duplication.
- Assert rst while in ACTIVE with 3 flits queued -> next cycle sa_req=0, in_ready=1, FIFO empty, state IDLE.
